// File: rtl/constraint_pkg.sv
// Shared types for the rope constraint datapath: fixed-point format,
// sequencer state encoding and the 2-D position vector.
package constraint_pkg;

  localparam int FIX_W    = 32;
  localparam int FIX_FRAC = 16;

  typedef enum logic [2:0] {
    IDLE,
    PRIME,
    FETCH,
    ISSUE,
    WAIT_RES,
    WRITE,
    DONE
  } state_t;

  typedef struct packed {
    logic signed [FIX_W-1:0] x;
    logic signed [FIX_W-1:0] y;
  } vec2_t;

endpackage

// File: rtl/node_window.sv
// Three-slot (up, cur, down) window over the node chain. A shift moves the
// window one node down the rope, injecting the corrected node as the new up.
module node_window
  import constraint_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  ld_up,
  input  logic  ld_cur,
  input  logic  ld_down,
  input  vec2_t ld_data,
  input  logic  shift,
  input  vec2_t inject,
  output vec2_t up,
  output vec2_t cur,
  output vec2_t down
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      up   <= '0;
      cur  <= '0;
      down <= '0;
    end else if (shift) begin
      up  <= inject;
      cur <= down;
    end else begin
      if (ld_up)   up   <= ld_data;
      if (ld_cur)  cur  <= ld_data;
      if (ld_down) down <= ld_data;
    end
  end

endmodule

// File: rtl/constraint_sweep_sequencer.sv
// Gauss-Seidel sweep sequencer: streams (up, self, down) triples from the
// position RAM through the constraint unit and writes nodes 1..N-1 back.
module constraint_sweep_sequencer
  import constraint_pkg::*;
#(
  parameter int N_NODES = 16,
  parameter int ADDR_W  = 4,
  parameter int DATA_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [3:0]        iters,
  output logic              busy,
  output logic              done,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_x,
  input  logic [DATA_W-1:0] mem_rd_y,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [DATA_W-1:0] mem_wr_x,
  output logic [DATA_W-1:0] mem_wr_y,
  output logic              cu_valid,
  input  logic              cu_ready,
  output logic [DATA_W-1:0] cu_up_x,
  output logic [DATA_W-1:0] cu_up_y,
  output logic [DATA_W-1:0] cu_x,
  output logic [DATA_W-1:0] cu_y,
  output logic [DATA_W-1:0] cu_down_x,
  output logic [DATA_W-1:0] cu_down_y,
  input  logic              cu_res_valid,
  input  logic [DATA_W-1:0] cu_res_x,
  input  logic [DATA_W-1:0] cu_res_y
);

  localparam int CW = ADDR_W + 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(N_NODES - 1);
  localparam logic [CW-1:0] END_IDX  = CW'(N_NODES);

  state_t        state, state_n;
  logic          phase, phase_n;
  logic [CW-1:0] idx;
  logic [3:0]    sweeps;
  logic          pend_up, pend_cur, pend_down;
  logic          accept, rd_up, rd_cur, rd_down, copy_down;
  logic          capture, advance, sweep_end;
  vec2_t         res, w_up, w_cur, w_down, ld_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n     = state;
    phase_n     = phase;
    busy        = 1'b0;
    done        = 1'b0;
    mem_rd_en   = 1'b0;
    mem_rd_addr = '0;
    mem_wr_en   = 1'b0;
    mem_wr_addr = '0;
    cu_valid    = 1'b0;
    accept      = 1'b0;
    rd_up       = 1'b0;
    rd_cur      = 1'b0;
    rd_down     = 1'b0;
    copy_down   = 1'b0;
    capture     = 1'b0;
    advance     = 1'b0;
    sweep_end   = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          accept  = 1'b1;
          phase_n = 1'b0;
          state_n = PRIME;
        end
      end
      PRIME: begin
        busy      = 1'b1;
        mem_rd_en = 1'b1;
        if (!phase) begin
          rd_up   = 1'b1;
          phase_n = 1'b1;
        end else begin
          mem_rd_addr = ADDR_W'(1);
          rd_cur      = 1'b1;
          phase_n     = 1'b0;
          state_n     = FETCH;
        end
      end
      FETCH: begin
        busy = 1'b1;
        // idx == N_NODES lands here after the final write-back of a sweep
        if (idx == END_IDX) begin
          sweep_end = 1'b1;
          state_n   = (sweeps == 4'd1) ? DONE : PRIME;
        end else if (idx == LAST_IDX) begin
          copy_down = 1'b1;
          state_n   = ISSUE;
        end else if (!phase) begin
          mem_rd_en   = 1'b1;
          mem_rd_addr = ADDR_W'(idx + 1'b1);
          rd_down     = 1'b1;
          phase_n     = 1'b1;
        end else begin
          phase_n = 1'b0;
          state_n = ISSUE;
        end
      end
      ISSUE: begin
        busy     = 1'b1;
        cu_valid = 1'b1;
        if (cu_ready) begin
          capture = cu_res_valid;
          state_n = cu_res_valid ? WRITE : WAIT_RES;
        end
      end
      WAIT_RES: begin
        busy = 1'b1;
        if (cu_res_valid) begin
          capture = 1'b1;
          state_n = WRITE;
        end
      end
      WRITE: begin
        busy        = 1'b1;
        mem_wr_en   = 1'b1;
        mem_wr_addr = idx[ADDR_W-1:0];
        advance     = 1'b1;
        state_n     = FETCH;
      end
      DONE: begin
        done    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase     <= 1'b0;
      idx       <= '0;
      sweeps    <= '0;
      pend_up   <= 1'b0;
      pend_cur  <= 1'b0;
      pend_down <= 1'b0;
      res       <= '0;
    end else begin
      phase     <= phase_n;
      pend_up   <= rd_up;
      pend_cur  <= rd_cur;
      pend_down <= rd_down;
      if (accept) begin
        idx    <= CW'(1);
        sweeps <= (iters == 4'd0) ? 4'd1 : iters;
      end
      if (sweep_end) begin
        idx    <= CW'(1);
        sweeps <= sweeps - 4'd1;
      end
      if (advance) idx <= idx + 1'b1;
      if (capture) res <= vec2_t'({cu_res_x, cu_res_y});
    end
  end

  // Read data lands one cycle after its strobe; the last node copies self into down.
  assign ld_data = copy_down ? w_cur : vec2_t'({mem_rd_x, mem_rd_y});

  node_window u_window (
    .clk     (clk),
    .rst_n   (rst_n),
    .ld_up   (pend_up),
    .ld_cur  (pend_cur),
    .ld_down (pend_down | copy_down),
    .ld_data (ld_data),
    .shift   (advance),
    .inject  (res),
    .up      (w_up),
    .cur     (w_cur),
    .down    (w_down)
  );

  assign cu_up_x   = w_up.x;
  assign cu_up_y   = w_up.y;
  assign cu_x      = w_cur.x;
  assign cu_y      = w_cur.y;
  assign cu_down_x = w_down.x;
  assign cu_down_y = w_down.y;
  assign mem_wr_x  = res.x;
  assign mem_wr_y  = res.y;

endmodule

// File: tb/tb_constraint_sweep_sequencer.sv
// Bench for constraint_sweep_sequencer: RAM model, stub constraint unit with
// programmable stalls/latency, and a whole-sweep reference model.
module tb_constraint_sweep_sequencer;

  localparam int N  = 4;
  localparam int AW = 4;
  localparam int DW = 32;

  typedef struct packed {logic [31:0] ux, uy, sx, sy, dx, dy;} trip_t;
  typedef struct packed {logic [3:0] addr; logic [31:0] x, y;} wr_t;

  logic          clk = 1'b0;
  logic          rst_n, start, busy, done;
  logic [3:0]    iters;
  logic          mem_rd_en, mem_wr_en, cu_valid, cu_ready, cu_res_valid;
  logic [AW-1:0] mem_rd_addr, mem_wr_addr;
  logic [DW-1:0] mem_rd_x, mem_rd_y, mem_wr_x, mem_wr_y;
  logic [DW-1:0] cu_up_x, cu_up_y, cu_x, cu_y, cu_down_x, cu_down_y;
  logic [DW-1:0] cu_res_x, cu_res_y;

  always #5 clk = ~clk;

  constraint_sweep_sequencer #(.N_NODES(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .iters(iters), .busy(busy), .done(done),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_x(mem_rd_x), .mem_rd_y(mem_rd_y),
    .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_x(mem_wr_x), .mem_wr_y(mem_wr_y),
    .cu_valid(cu_valid), .cu_ready(cu_ready),
    .cu_up_x(cu_up_x), .cu_up_y(cu_up_y), .cu_x(cu_x), .cu_y(cu_y),
    .cu_down_x(cu_down_x), .cu_down_y(cu_down_y),
    .cu_res_valid(cu_res_valid), .cu_res_x(cu_res_x), .cu_res_y(cu_res_y)
  );

  int checks = 0, failures = 0;
  int mode = 0;
  int stall_tab[64], lat_tab[64];
  logic preload = 1'b0, stub_clr = 1'b0;
  logic [31:0] init_x[N], init_y[N], mx[N], my[N];
  logic [31:0] ram_x[16], ram_y[16];
  trip_t obs_iss[$], exp_iss[$];
  wr_t   obs_wr[$], exp_wr[$];
  int bad_rd = 0, unstable = 0, done_cnt = 0;

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Stand-in constraint unit: a fixed function of the triple it was handed.
  function automatic logic [63:0] stub_fn(input int md, input trip_t t);
    if (md == 0) return {t.sx + 32'h100, t.sy};
    return {t.sx + 32'h100 + ((t.ux ^ t.dx) >> 5), t.sy - (t.uy >> 3) + t.dy};
  endfunction

  // RAM: registered read, write on clock edge.
  always @(posedge clk) begin
    if (preload) begin
      for (int k = 0; k < 16; k++) begin
        ram_x[k] <= (k < N) ? init_x[k] : 32'h0;
        ram_y[k] <= (k < N) ? init_y[k] : 32'h0;
      end
    end else if (mem_wr_en) begin
      ram_x[mem_wr_addr] <= mem_wr_x;
      ram_y[mem_wr_addr] <= mem_wr_y;
    end
    if (mem_rd_en) begin
      mem_rd_x <= ram_x[mem_rd_addr];
      mem_rd_y <= ram_y[mem_rd_addr];
    end
  end

  trip_t       cur_t;
  logic [63:0] live, hold;
  int          txn, wait_cnt, pend_cnt;
  logic        pend;

  always_comb cur_t = {cu_up_x, cu_up_y, cu_x, cu_y, cu_down_x, cu_down_y};
  always_comb live = stub_fn(mode, cur_t);
  assign cu_ready = cu_valid && (wait_cnt >= stall_tab[txn]);
  assign cu_res_valid = (cu_valid && cu_ready && lat_tab[txn] == 0) || (pend && pend_cnt == 1);
  assign {cu_res_x, cu_res_y} = pend ? hold : live;

  always @(posedge clk) begin
    if (!rst_n || stub_clr) begin
      txn <= 0; wait_cnt <= 0; pend <= 1'b0; pend_cnt <= 0; hold <= '0;
    end else if (cu_valid && cu_ready) begin
      wait_cnt <= 0;
      txn      <= txn + 1;
      if (lat_tab[txn] != 0) begin
        pend <= 1'b1; pend_cnt <= lat_tab[txn]; hold <= live;
      end
    end else begin
      if (cu_valid) wait_cnt <= wait_cnt + 1;
      if (pend) begin
        if (pend_cnt == 1) pend <= 1'b0;
        else pend_cnt <= pend_cnt - 1;
      end
    end
  end

  trip_t hold_t;
  logic  hold_v = 1'b0;
  always @(negedge clk) begin
    if (stub_clr) begin
      obs_wr.delete(); obs_iss.delete();
      bad_rd = 0; unstable = 0; hold_v = 1'b0;
    end else begin
      if (mem_wr_en) obs_wr.push_back({mem_wr_addr, mem_wr_x, mem_wr_y});
      if (mem_rd_en && mem_rd_addr >= 4'(N)) bad_rd++;
      if (cu_valid) begin
        if (hold_v && cur_t != hold_t) unstable++;
        if (cu_ready) begin
          obs_iss.push_back(cur_t);
          hold_v = 1'b0;
        end else begin
          hold_t = cur_t;
          hold_v = 1'b1;
        end
      end else hold_v = 1'b0;
    end
    if (done) done_cnt++;
  end

  task automatic model_init();
    for (int k = 0; k < N; k++) begin
      mx[k] = init_x[k];
      my[k] = init_y[k];
    end
  endtask

  // Gauss-Seidel over the chain: node 0 fixed, last node sees itself as down.
  task automatic model_run(input int sweeps, input int limit);
    trip_t t;
    logic [63:0] r;
    exp_wr.delete(); exp_iss.delete();
    for (int s = 0; s < sweeps; s++) begin
      for (int i = 1; i < N; i++) begin
        int dn;
        dn = (i < N - 1) ? i + 1 : i;
        if (exp_wr.size() >= limit) return;
        t = {mx[i-1], my[i-1], mx[i], my[i], mx[dn], my[dn]};
        exp_iss.push_back(t);
        r = stub_fn(mode, t);
        mx[i] = r[63:32];
        my[i] = r[31:0];
        exp_wr.push_back({4'(i), r});
      end
    end
  endtask

  function automatic int exp_lat(input int sw);
    int t;
    t = sw * (2 + 4 * (N - 1));
    for (int k = 0; k < sw * (N - 1); k++) t += stall_tab[k] + lat_tab[k];
    return t;
  endfunction

  task automatic prep(input logic load);
    for (int k = 0; k < 64; k++) begin
      stall_tab[k] = 0;
      lat_tab[k]   = 0;
    end
    preload = load; stub_clr = 1'b1;
    @(negedge clk);
    preload = 1'b0; stub_clr = 1'b0;
  endtask

  task automatic run_sweep(input logic [3:0] it, input logic spurious, output int lat);
    int d0;
    d0 = done_cnt;
    @(negedge clk); start = 1'b1; iters = it;
    @(negedge clk); start = 1'b0; iters = 4'($urandom);
    check("busy_rise", busy, 1);
    lat = 0;
    while (!done && lat < 3000) begin
      @(negedge clk);
      lat++;
      start = spurious && !done && ($urandom_range(0, 4) == 0);
    end
    start = 1'b0;
    check("done_seen", done, 1);
    check("done_busy_low", busy, 0);
    @(negedge clk); @(negedge clk);
    check("done_pulses", done_cnt - d0, 1);
  endtask

  task automatic compare_run(input string tag, input int lat, input int lat_exp);
    check({tag, "_latency"}, lat, lat_exp);
    check({tag, "_nwr"}, obs_wr.size(), exp_wr.size());
    for (int k = 0; k < exp_wr.size() && k < obs_wr.size(); k++)
      check({tag, "_wr"}, obs_wr[k], exp_wr[k]);
    check({tag, "_niss"}, obs_iss.size(), exp_iss.size());
    for (int k = 0; k < exp_iss.size() && k < obs_iss.size(); k++) begin
      check({tag, "_up"},   {obs_iss[k].ux, obs_iss[k].uy}, {exp_iss[k].ux, exp_iss[k].uy});
      check({tag, "_self"}, {obs_iss[k].sx, obs_iss[k].sy}, {exp_iss[k].sx, exp_iss[k].sy});
      check({tag, "_down"}, {obs_iss[k].dx, obs_iss[k].dy}, {exp_iss[k].dx, exp_iss[k].dy});
    end
    for (int k = 0; k < N; k++) check({tag, "_ram"}, {ram_x[k], ram_y[k]}, {mx[k], my[k]});
    check({tag, "_bad_rd"}, bad_rd, 0);
    check({tag, "_unstable"}, unstable, 0);
  endtask

  initial begin
    int lat, it, eff;
    rst_n = 1'b0; start = 1'b0; iters = '0;
    for (int k = 0; k < 64; k++) begin stall_tab[k] = 0; lat_tab[k] = 0; end
    repeat (3) @(negedge clk);
    check("rst_ctl", {busy, done, cu_valid, mem_wr_en, mem_rd_en}, 0);
    check("rst_addr", {mem_rd_addr, mem_wr_addr}, 0);
    check("rst_tri", {cu_up_x, cu_up_y, cu_x}, 0);
    check("rst_wr", {cu_y, mem_wr_x, mem_wr_y}, 0);
    rst_n = 1'b1;

    // Straight chain x = 0,1.0,2.0,3.0; +0x100 per correction.
    for (int k = 0; k < N; k++) begin init_x[k] = 32'(k) << 16; init_y[k] = 0; end
    mode = 0;
    prep(1'b1); model_init(); model_run(1, 1000);
    run_sweep(4'd1, 1'b0, lat);
    compare_run("basic", lat, 14);
    if (obs_wr.size() == 3) begin
      check("basic_wr1", {obs_wr[0].addr, obs_wr[0].x}, {4'd1, 32'h10100});
      check("basic_wr3", {obs_wr[2].addr, obs_wr[2].x}, {4'd3, 32'h30100});
    end
    if (obs_iss.size() == 3) begin
      check("gs_up_node2", obs_iss[1].ux, 32'h10100);
      check("last_down_x", obs_iss[2].dx, 32'h30000);
      check("last_self_x", obs_iss[2].sx, 32'h30000);
    end

    // Back-pressure: five cycles of cu_ready low on node 2.
    prep(1'b1); stall_tab[1] = 5; model_init(); model_run(1, 1000);
    run_sweep(4'd1, 1'b0, lat);
    compare_run("bp", lat, 19);

    // Three sweeps with stray start pulses while busy.
    prep(1'b1); model_init(); model_run(3, 1000);
    run_sweep(4'd3, 1'b1, lat);
    compare_run("iter3", lat, 42);
    check("iter3_node1", ram_x[1], 32'h10300);

    // Reset while waiting for node 2's result.
    prep(1'b1); lat_tab[1] = 10; model_init(); model_run(1, 1);
    @(negedge clk); start = 1'b1; iters = 4'd1;
    @(negedge clk); start = 1'b0;
    for (int n = 0; n < 200 && obs_iss.size() < 2; n++) @(negedge clk);
    check("rst_reach_node2", obs_iss.size(), 2);
    @(negedge clk); @(negedge clk);
    check("rst_pre_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("midrst_ctl", {busy, done, cu_valid, mem_wr_en, mem_rd_en}, 0);
    check("midrst_tri", {cu_up_x, cu_x, cu_down_x}, 0);
    check("midrst_wr", {mem_wr_addr, mem_wr_x, mem_wr_y}, 0);
    repeat (3) @(negedge clk);
    check("midrst_nwr", obs_wr.size(), 1);
    if (obs_wr.size() > 0) check("midrst_wr_addr", obs_wr[0].addr, 1);
    for (int k = 0; k < N; k++) check("midrst_ram", {ram_x[k], ram_y[k]}, {mx[k], my[k]});
    rst_n = 1'b1;
    prep(1'b0); model_run(1, 1000);
    run_sweep(4'd1, 1'b0, lat);
    compare_run("post_rst", lat, 14);

    // Randomized chains, sweep counts, stalls and result latencies.
    mode = 1;
    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < N; k++) begin init_x[k] = $urandom; init_y[k] = $urandom; end
      prep(1'b1);
      for (int k = 0; k < 64; k++) begin
        stall_tab[k] = $urandom_range(0, 3);
        lat_tab[k]   = $urandom_range(0, 3);
      end
      it  = $urandom_range(0, 15);
      eff = (it == 0) ? 1 : it;
      model_init(); model_run(eff, 1000);
      run_sweep(4'(it), 1'b1, lat);
      compare_run("rnd", lat, exp_lat(eff));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/constraint_sweep_sequencer.md
Name: constraint_sweep_sequencer

Overview:
- Drives the rope constraint unit across the whole node chain.
- Reads node positions from the position RAM and presents each (up, self, down) triple to the constraint unit, then writes the corrected position back.
- Sweeps run Gauss-Seidel style: a node's "up" neighbour is always its already-corrected value.
- Sits between the position RAM and the combinational constraint stage; one sweep per simulation substep, repeated `iters` times.

Parameters:
- N_NODES, 16, number of rope nodes; minimum 3.
- ADDR_W, 4, RAM address width; must satisfy 2^ADDR_W >= N_NODES.
- DATA_W, 32, coordinate width, signed Q16.16 fixed point.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins `iters` sweeps when idle.
- iters  in  4  sweep count, sampled on start; 0 treated as 1.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse after the last write-back.
- mem_rd_en  out  1  RAM read strobe.
- mem_rd_addr  out  ADDR_W  RAM read address.
- mem_rd_x, mem_rd_y  in  DATA_W  RAM read data, valid one cycle after mem_rd_en.
- mem_wr_en  out  1  RAM write strobe.
- mem_wr_addr  out  ADDR_W  RAM write address.
- mem_wr_x, mem_wr_y  out  DATA_W  RAM write data.
- cu_valid  out  1  triple presented to the constraint unit.
- cu_ready  in  1  constraint unit accepts the triple.
- cu_up_x, cu_up_y, cu_x, cu_y, cu_down_x, cu_down_y  out  DATA_W  triple to the constraint unit.
- cu_res_valid  in  1  corrected position valid.
- cu_res_x, cu_res_y  in  DATA_W  corrected position.

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, window registers 0, counters 0.
- Node 0 is pinned: it is read but never written.
- For node i in 1..N_NODES-1: up = window value of node i-1 (post-correction), self = node i, down = node i+1.
- For the last node, down = self, so the unit sees a zero down delta.
- FSM states:
  - IDLE: start accepted here; start while busy is ignored.
  - PRIME: read addr 0 then addr 1; data loaded into up/self one cycle after each read.
  - FETCH: if i < N_NODES-1, read addr i+1 and load down; else copy self into down. Takes 2 cycles, or 1 for the last node.
  - ISSUE: cu_valid=1 with triple outputs stable until the cycle cu_ready=1; transfer occurs on valid&&ready.
  - WAIT_RES: hold until cu_res_valid. A result arriving in the same cycle as the ISSUE handshake is captured; go directly to WRITE.
  - WRITE: for exactly one cycle, mem_wr_en=1, mem_wr_addr=i, data=cu_res. Then shift the window: up<=result, self<=down. Then i<=i+1.
  - Sweep end (i reaches N_NODES): decrement the sweep counter. If nonzero, go to PRIME with i=1; else go to DONE.
  - DONE: done=1 for one cycle, busy=0 in the same cycle, then IDLE.
- Reads and writes never target the same address in the same cycle, so no RAM read-during-write hazard exists.
- Throughput without back-pressure: 4 cycles per node (FETCH 2 + ISSUE 1 + WRITE 1), plus 2 PRIME cycles per sweep.
- Asynchronous reset mid-sweep: immediate return to IDLE with no further RAM writes. A partially corrected chain is left in RAM, which is acceptable.
- Counter widths: i is ADDR_W+1 bits so the terminal compare cannot wrap; the sweep counter is 4 bits.
- No arithmetic in this block; data passes through bit-exact.

Decomposition:
- Shared package constraint_pkg:
  - FIX_W=32, FIX_FRAC=16.
  - State enum {IDLE, PRIME, FETCH, ISSUE, WAIT_RES, WRITE, DONE}.
  - Packed struct vec2_t {x, y}, reused by the constraint unit and the integrator.
- One sub-module: node_window, a 3-entry vec2_t shift register with per-slot load and a shift-with-inject-up operation.

Test Plan:
- N_NODES=4, RAM x=0,1.0,2.0,3.0 (0x0,0x10000,0x20000,0x30000), y=0; stub unit returns self+0x100, cu_ready=1, 0-cycle result, iters=1.
  - Expect writes to addr 1,2,3 only, values x=0x10100,0x20100,0x30100.
  - Expect done 14 cycles after busy rises.
- Same setup, check the Gauss-Seidel chain: on issue for node 2, cu_up_x=0x10100 (corrected node 1, not 0x10000).
- Last node: on node 3 issue, cu_down_x=cu_x=0x30000, and no read of addr 4 occurs.
- Back-pressure: cu_ready low for 5 cycles on node 2.
  - Expect triple outputs stable throughout and cu_valid held.
  - Expect single write, done delayed by exactly 5 cycles.
- iters=3: expect 9 writes total, node 1 final x=0x10300, exactly one done pulse, start pulses during busy ignored.
- Assert rst_n low during WAIT_RES of node 2: outputs zero immediately, no write to addr 2; a fresh start afterwards runs a clean sweep.
